// File: rtl/axi_lite_modport_pkg.sv
// axi_lite_modport_pkg: shared AXI-Lite widths and response codes for the slave endpoint
package axi_lite_modport_pkg;
   localparam int AXIL_ADDR_W = 32;
   localparam int AXIL_DATA_W = 32;
   localparam int AXIL_STRB_W = 4;
   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_t;
endpackage

// File: rtl/axi_lite_modport_if.sv
// axi_lite_modport_if: AXI-Lite link bundle with master and slave views
interface axi_lite_modport_if;
   import axi_lite_modport_pkg::*;
   logic [AXIL_ADDR_W-1:0] awaddr;
   logic [2:0]             awprot;
   logic                   awvalid;
   logic                   awready;
   logic [AXIL_DATA_W-1:0] wdata;
   logic [AXIL_STRB_W-1:0] wstrb;
   logic                   wvalid;
   logic                   wready;
   logic [1:0]             bresp;
   logic                   bvalid;
   logic                   bready;
   logic [AXIL_ADDR_W-1:0] araddr;
   logic [2:0]             arprot;
   logic                   arvalid;
   logic                   arready;
   logic [AXIL_DATA_W-1:0] rdata;
   logic [1:0]             rresp;
   logic                   rvalid;
   logic                   rready;
   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi_lite_modport_regfile.sv
// axi_lite_modport_regfile: NUM_REGS x 32 registers, byte-enabled sync write, async read
module axi_lite_modport_regfile
   import axi_lite_modport_pkg::*;
#(
   parameter int                     NUM_REGS  = 16,
   parameter logic [AXIL_DATA_W-1:0] RESET_VAL = '0,
   parameter int                     IDX_W     = $clog2(NUM_REGS)
) (
   input  logic                   clk,
   input  logic                   aresetn,
   input  logic                   we,
   input  logic [IDX_W-1:0]       wr_idx,
   input  logic [AXIL_DATA_W-1:0] wr_data,
   input  logic [AXIL_STRB_W-1:0] wr_strb,
   input  logic [IDX_W-1:0]       rd_idx,
   output logic [AXIL_DATA_W-1:0] rd_data
);
   logic [AXIL_DATA_W-1:0] regs [NUM_REGS];
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
      end else if (we) begin
         for (int b = 0; b < AXIL_STRB_W; b++)
            if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
   end
   assign rd_data = regs[rd_idx];
endmodule

// File: rtl/axi_lite_modport.sv
// axi_lite_modport: AXI-Lite slave endpoint over a byte-writable register file.
// Define AXIL_MODPORT_PROT_CHECK_EN to reject unprivileged (prot[0]=0) accesses with SLVERR.
module axi_lite_modport
   import axi_lite_modport_pkg::*;
#(
   parameter int                     NUM_REGS  = 16,
   parameter logic [AXIL_DATA_W-1:0] RESET_VAL = '0
) (
   input logic               aclk,
   input logic               aresetn,
   axi_lite_modport_if.slave s
);
   localparam int IDX_W = $clog2(NUM_REGS);
   localparam logic [1:0] RD_INIT = 2'd0, RD_IDLE = 2'd1, RD_ADDR = 2'd2, RD_RESP = 2'd3;
   logic [AXIL_ADDR_W-1:2] aw_addr, ar_addr;
   logic [AXIL_DATA_W-1:0] w_data, rd_data;
   logic [AXIL_STRB_W-1:0] w_strb;
   logic                   aw_held, w_held, up, commit, bad_w, bad_r;
   logic [1:0]             rd_state;
`ifdef AXIL_MODPORT_PROT_CHECK_EN
   logic aw_priv, ar_priv;
   assign bad_w = |aw_addr[AXIL_ADDR_W-1:2+IDX_W] || !aw_priv;
   assign bad_r = |ar_addr[AXIL_ADDR_W-1:2+IDX_W] || !ar_priv;
`else
   assign bad_w = |aw_addr[AXIL_ADDR_W-1:2+IDX_W];
   assign bad_r = |ar_addr[AXIL_ADDR_W-1:2+IDX_W];
`endif
   assign commit = aw_held && w_held;
   axi_lite_modport_regfile #(.NUM_REGS(NUM_REGS), .RESET_VAL(RESET_VAL)) u_regfile (
      .clk     (aclk),
      .aresetn (aresetn),
      .we      (commit && !bad_w),
      .wr_idx  (aw_addr[2 +: IDX_W]),
      .wr_data (w_data),
      .wr_strb (w_strb),
      .rd_idx  (ar_addr[2 +: IDX_W]),
      .rd_data (rd_data)
   );
   // AW and W are held independently; the write commits the edge after both are present
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         up        <= 1'b0;
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         aw_addr   <= '0;
         w_data    <= '0;
         w_strb    <= '0;
         s.awready <= 1'b0;
         s.wready  <= 1'b0;
         s.bvalid  <= 1'b0;
         s.bresp   <= OKAY;
`ifdef AXIL_MODPORT_PROT_CHECK_EN
         aw_priv   <= 1'b0;
`endif
      end else begin
         if (!up) begin
            up        <= 1'b1;
            s.awready <= 1'b1;
            s.wready  <= 1'b1;
         end
         if (s.awvalid && s.awready) begin
            aw_addr   <= s.awaddr[AXIL_ADDR_W-1:2];
            aw_held   <= 1'b1;
            s.awready <= 1'b0;
`ifdef AXIL_MODPORT_PROT_CHECK_EN
            aw_priv   <= s.awprot[0];
`endif
         end
         if (s.wvalid && s.wready) begin
            w_data   <= s.wdata;
            w_strb   <= s.wstrb;
            w_held   <= 1'b1;
            s.wready <= 1'b0;
         end
         if (commit) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            s.bvalid <= 1'b1;
            s.bresp  <= bad_w ? SLVERR : OKAY;
         end
         if (s.bvalid && s.bready) begin
            s.bvalid  <= 1'b0;
            s.awready <= 1'b1;
            s.wready  <= 1'b1;
         end
      end
   end
   // rdata is sampled from the pre-commit array, so a coincident write is not visible
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         rd_state  <= RD_INIT;
         ar_addr   <= '0;
         s.arready <= 1'b0;
         s.rvalid  <= 1'b0;
         s.rdata   <= '0;
         s.rresp   <= OKAY;
`ifdef AXIL_MODPORT_PROT_CHECK_EN
         ar_priv   <= 1'b0;
`endif
      end else if (rd_state == RD_INIT) begin
         rd_state  <= RD_IDLE;
         s.arready <= 1'b1;
      end else if (rd_state == RD_IDLE) begin
         if (s.arvalid) begin
            rd_state  <= RD_ADDR;
            ar_addr   <= s.araddr[AXIL_ADDR_W-1:2];
            s.arready <= 1'b0;
`ifdef AXIL_MODPORT_PROT_CHECK_EN
            ar_priv   <= s.arprot[0];
`endif
         end
      end else if (rd_state == RD_ADDR) begin
         rd_state <= RD_RESP;
         s.rvalid <= 1'b1;
         s.rdata  <= bad_r ? '0 : rd_data;
         s.rresp  <= bad_r ? SLVERR : OKAY;
      end else if (s.rready) begin
         rd_state  <= RD_IDLE;
         s.rvalid  <= 1'b0;
         s.arready <= 1'b1;
      end
   end
endmodule

// File: tb/tb_axi_lite_modport.sv
// tb_axi_lite_modport: table-driven write/readback vectors plus hand sequences for overlap and reset
module tb_axi_lite_modport;
   logic aclk, aresetn;
   int   vecs, errs;
   axi_lite_modport_if bus ();
   axi_lite_modport #(.NUM_REGS(16), .RESET_VAL(32'h0)) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .s       (bus)
   );
   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end
   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          awd;
      int          wd;
      int          bd;
      int          rd;
      logic [1:0]  bresp;
      logic [31:0] rdata;
      logic [1:0]  rresp;
   } vec_t;
   vec_t tbl [8];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask
   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                           input int awd, input int wd, input int bd, input logic [1:0] exp);
      bit aw_done, w_done, hs_aw, hs_w;
      int n;
      aw_done = 0;
      w_done  = 0;
      n       = 0;
      bus.awaddr = a;
      bus.wdata  = d;
      bus.wstrb  = st;
      while (!(aw_done && w_done) && n < 40) begin
         bus.awvalid = !aw_done && n >= awd;
         bus.wvalid  = !w_done && n >= wd;
         hs_aw = bus.awvalid && bus.awready;
         hs_w  = bus.wvalid && bus.wready;
         @(posedge aclk); #1;
         n++;
         aw_done |= hs_aw;
         w_done  |= hs_w;
      end
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      chk("wr_handshake", {31'b0, aw_done && w_done}, 32'd1);
      if (!(aw_done && w_done)) return;
      chk("bvalid_early", {31'b0, bus.bvalid}, 32'd0);
      @(posedge aclk); #1;
      chk("bvalid", {31'b0, bus.bvalid}, 32'd1);
      chk("bresp", {30'b0, bus.bresp}, {30'b0, exp});
      repeat (bd) begin
         @(posedge aclk); #1;
         chk("bvalid_hold", {31'b0, bus.bvalid}, 32'd1);
         chk("bresp_hold", {30'b0, bus.bresp}, {30'b0, exp});
      end
      bus.bready = 1'b1;
      @(posedge aclk); #1;
      bus.bready = 1'b0;
      chk("bvalid_clr", {31'b0, bus.bvalid}, 32'd0);
      chk("aw_w_ready_back", {30'b0, bus.awready, bus.wready}, 32'd3);
   endtask
   task automatic do_read(input logic [31:0] a, input int rd, input logic [31:0] exp_d,
                          input logic [1:0] exp_r);
      int n;
      n = 0;
      bus.araddr  = a;
      bus.arvalid = 1'b1;
      while (!bus.arready && n < 40) begin
         @(posedge aclk); #1;
         n++;
      end
      chk("ar_wait", {31'b0, bus.arready}, 32'd1);
      if (!bus.arready) begin
         bus.arvalid = 1'b0;
         return;
      end
      @(posedge aclk); #1;
      bus.arvalid = 1'b0;
      chk("rvalid_early", {31'b0, bus.rvalid}, 32'd0);
      chk("arready_drop", {31'b0, bus.arready}, 32'd0);
      @(posedge aclk); #1;
      chk("rvalid", {31'b0, bus.rvalid}, 32'd1);
      chk("rdata", bus.rdata, exp_d);
      chk("rresp", {30'b0, bus.rresp}, {30'b0, exp_r});
      repeat (rd) begin
         @(posedge aclk); #1;
         chk("rvalid_hold", {31'b0, bus.rvalid}, 32'd1);
         chk("rdata_hold", bus.rdata, exp_d);
      end
      bus.rready = 1'b1;
      @(posedge aclk); #1;
      bus.rready = 1'b0;
      chk("rvalid_clr", {31'b0, bus.rvalid}, 32'd0);
      chk("arready_back", {31'b0, bus.arready}, 32'd1);
   endtask
   initial begin
      vecs = 0;
      errs = 0;
      tbl[0] = '{32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 2'b00, 32'hDEADBEEF, 2'b00};
      tbl[1] = '{32'h08, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 0, 2'b00, 32'hFFFFFFFF, 2'b00};
      tbl[2] = '{32'h08, 32'h12345678, 4'h5, 0, 5, 3, 0, 2'b00, 32'hFF34FF78, 2'b00};
      tbl[3] = '{32'h08, 32'h00000000, 4'h0, 4, 0, 1, 2, 2'b00, 32'hFF34FF78, 2'b00};
      tbl[4] = '{32'h00, 32'hA5A5A5A5, 4'hF, 2, 2, 0, 0, 2'b00, 32'hA5A5A5A5, 2'b00};
      tbl[5] = '{32'h40, 32'hCAFEBABE, 4'hF, 0, 1, 0, 1, 2'b10, 32'h00000000, 2'b10};
      tbl[6] = '{32'h3E, 32'h0BADF00D, 4'hC, 1, 3, 2, 0, 2'b00, 32'h0BAD0000, 2'b00};
      tbl[7] = '{32'h80000000, 32'h55555555, 4'hF, 0, 0, 0, 0, 2'b10, 32'h00000000, 2'b10};
      aresetn     = 1'b0;
      bus.awaddr  = '0;
      bus.awprot  = 3'b001;
      bus.awvalid = 1'b0;
      bus.wdata   = '0;
      bus.wstrb   = '0;
      bus.wvalid  = 1'b0;
      bus.bready  = 1'b0;
      bus.araddr  = '0;
      bus.arprot  = 3'b001;
      bus.arvalid = 1'b0;
      bus.rready  = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      chk("rst_readies", {29'b0, bus.awready, bus.wready, bus.arready}, 32'd0);
      chk("rst_valids", {30'b0, bus.bvalid, bus.rvalid}, 32'd0);
      chk("rst_resps", {28'b0, bus.bresp, bus.rresp}, 32'd0);
      chk("rst_rdata", bus.rdata, 32'd0);
      aresetn = 1'b1;
      chk("ready_before_edge", {29'b0, bus.awready, bus.wready, bus.arready}, 32'd0);
      @(posedge aclk); #1;
      chk("ready_after_rst", {29'b0, bus.awready, bus.wready, bus.arready}, 32'd7);
      for (int i = 0; i < 8; i++) begin
         do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].awd, tbl[i].wd, tbl[i].bd, tbl[i].bresp);
         do_read(tbl[i].addr, tbl[i].rd, tbl[i].rdata, tbl[i].rresp);
      end
      do_read(32'h00, 0, 32'hA5A5A5A5, 2'b00);
      do_read(32'h3C, 0, 32'h0BAD0000, 2'b00);
      do_write(32'h0C, 32'h11112222, 4'hF, 0, 0, 0, 2'b00);
      fork
         do_write(32'h0C, 32'h33334444, 4'hF, 0, 0, 0, 2'b00);
         do_read(32'h0C, 4, 32'h11112222, 2'b00);
      join
      do_read(32'h0C, 0, 32'h33334444, 2'b00);
      bus.awaddr  = 32'h04;
      bus.wdata   = 32'h77777777;
      bus.wstrb   = 4'hF;
      bus.awvalid = 1'b1;
      bus.wvalid  = 1'b1;
      @(posedge aclk); #1;
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      @(posedge aclk); #1;
      chk("rst_seq_bvalid", {31'b0, bus.bvalid}, 32'd1);
      aresetn = 1'b0;
      @(posedge aclk); #1;
      chk("midrst_bvalid", {31'b0, bus.bvalid}, 32'd0);
      chk("midrst_readies", {29'b0, bus.awready, bus.wready, bus.arready}, 32'd0);
      @(posedge aclk); #1;
      aresetn = 1'b1;
      @(posedge aclk); #1;
      chk("post_rst_ready", {29'b0, bus.awready, bus.wready, bus.arready}, 32'd7);
      chk("post_rst_bvalid", {31'b0, bus.bvalid}, 32'd0);
      do_read(32'h04, 0, 32'h00000000, 2'b00);
      do_read(32'h0C, 0, 32'h00000000, 2'b00);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
